// File: rtl/paddle_input_conditioner.sv
// paddle_input_conditioner: synchronise, debounce, tick-align and auto-repeat active-low paddle buttons
module paddle_input_conditioner #(
    parameter int NUM_BUTTONS         = 2,
    parameter int DEBOUNCE_CYCLES     = 500000,
    parameter int TICK_DIVIDER        = 833333,
    parameter int REPEAT_ENABLE       = 1,
    parameter int REPEAT_DELAY_TICKS  = 20,
    parameter int REPEAT_PERIOD_TICKS = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   pause,
    input  logic [NUM_BUTTONS-1:0] button_raw,
    output logic [NUM_BUTTONS-1:0] button_level,
    output logic [NUM_BUTTONS-1:0] button_out,
    output logic                   tick
);
    localparam int TW   = $clog2(TICK_DIVIDER);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY_TICKS > REPEAT_PERIOD_TICKS) ? REPEAT_DELAY_TICKS : REPEAT_PERIOD_TICKS;
    localparam int CW   = $clog2(RMAX + 1);
    localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIVIDER - 1);
    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY_TICKS - 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD_TICKS - 2);

    typedef enum logic [1:0] {RELEASED, HELD, GAP, REPEAT} state_t;

    logic [TW-1:0] tick_cnt;

    assign tick = (tick_cnt == TICK_LAST) && !pause;

    // free-running game tick counter, frozen while paused
    always_ff @(posedge clock or posedge reset)
        if (reset)
            tick_cnt <= '0;
        else if (!pause)
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : chan
        logic [1:0]    sync;
        logic [DW-1:0] db_cnt;
        logic          level;
        logic          out;
        state_t        state;
        logic [CW-1:0] rep_cnt;

        assign button_level[g] = level;
        assign button_out[g]   = out;

        // two-flop synchroniser for the asynchronous raw button
        always_ff @(posedge clock or posedge reset)
            if (reset)
                sync <= 2'b11;
            else
                sync <= {sync[0], button_raw[g]};

        // accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
        always_ff @(posedge clock or posedge reset)
            if (reset) begin
                db_cnt <= '0;
                level  <= 1'b1;
            end else if (sync[1] == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                level  <= sync[1];
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end

        // press, hold delay and auto-repeat shaping, advanced only on tick edges
        always_ff @(posedge clock or posedge reset)
            if (reset) begin
                state   <= RELEASED;
                rep_cnt <= '0;
                out     <= 1'b1;
            end else if (tick) begin
                if (level) begin
                    state <= RELEASED;
                    out   <= 1'b1;
                end else begin
                    case (state)
                        RELEASED: begin
                            state   <= HELD;
                            out     <= 1'b0;
                            rep_cnt <= '0;
                        end
                        HELD:
                            if (REPEAT_ENABLE != 0 && rep_cnt == DELAY_LAST) begin
                                state   <= GAP;
                                out     <= 1'b1;
                                rep_cnt <= '0;
                            end else if (rep_cnt != DELAY_LAST) begin
                                rep_cnt <= rep_cnt + 1'b1;
                            end
                        GAP: begin
                            state   <= REPEAT;
                            out     <= 1'b0;
                            rep_cnt <= '0;
                        end
                        REPEAT:
                            if (rep_cnt == PERIOD_LAST) begin
                                state <= GAP;
                                out   <= 1'b1;
                            end else begin
                                rep_cnt <= rep_cnt + 1'b1;
                            end
                        default: begin
                            state <= RELEASED;
                            out   <= 1'b1;
                        end
                    endcase
                end
            end
    end
endmodule

// File: doc/paddle_input_conditioner.md
Name: paddle_input_conditioner

Overview:
Conditions the raw, asynchronous, active-low player push-buttons before they reach the paddle movement stage. Each button is synchronised and debounced, then re-timed onto a game tick. Holding a button produces auto-repeat presses. The block also generates the periodic one-cycle tick that drives the paddle stage's enable input. Its outputs connect directly to that stage's button[1:0] and enable.

Parameters:
NUM_BUTTONS, 2, number of independent button channels (bit 0 = down, bit 1 = up)
DEBOUNCE_CYCLES, 500000, consecutive stable clock cycles needed to accept a new level (>=2)
TICK_DIVIDER, 833333, clock cycles per game tick (>=2)
REPEAT_ENABLE, 1, 1 = auto-repeat on hold, 0 = single press only
REPEAT_DELAY_TICKS, 20, tick windows a press is held low before the first repeat (>=1)
REPEAT_PERIOD_TICKS, 6, tick windows between successive falling edges during repeat (>=2)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
pause  input  1  1 = freeze tick generation and all tick-timed state
button_raw  input  NUM_BUTTONS  raw buttons, active-low, asynchronous, bouncy
button_level  output  NUM_BUTTONS  debounced level, active-low
button_out  output  NUM_BUTTONS  tick-aligned, repeat-shaped level, active-low; drives paddle button
tick  output  1  one-cycle pulse every TICK_DIVIDER cycles; drives paddle enable

Behaviour:
- Reset is asynchronous, active-high. Reset values:
  - sync flops, button_level, button_out: all 1s
  - tick: 0; tick counter: 0
  - debounce counters: 0
  - all channel FSMs: RELEASED, with repeat counters at 0
- Synchroniser: a 2-flop chain per bit. Both stages reset to 1.
- Debounce, per bit:
  - Compare the synchronised value s against button_level. If s == button_level, clear the counter.
  - Otherwise increment the counter. When it reaches DEBOUNCE_CYCLES-1, set button_level <= s and clear the counter.
  - A new level is accepted only after DEBOUNCE_CYCLES consecutive differing cycles. Any glitch shorter than that is ignored.
  - Latency from raw edge to button_level is 2 + DEBOUNCE_CYCLES cycles.
  - Debounce is not affected by pause.
- Tick generator:
  - The counter runs 0..TICK_DIVIDER-1 and wraps.
  - tick = 1 exactly while counter == TICK_DIVIDER-1 and pause == 0.
  - While pause = 1 the counter holds its value and tick = 0.
  - The first tick occurs in the TICK_DIVIDER-th cycle after reset deassertion.
- Tick window: the interval between consecutive tick edges. All FSM state and button_out update only on the clock edge where tick == 1. button_out is therefore constant for a whole tick window, and the paddle stage samples each level exactly once.
- Channel FSM, per bit. Every transition below is evaluated only at tick edges. Priority: a released button_level (1) is checked first in every state.
  - RELEASED, out = 1:
    - button_level == 0 → go to HELD, out = 0, cnt = 0.
  - HELD, out = 0:
    - Released → go to RELEASED, out = 1.
    - Otherwise cnt++. When REPEAT_ENABLE = 1 and this is the REPEAT_DELAY_TICKS-th tick in HELD → go to GAP, out = 1, cnt = 0.
    - When REPEAT_ENABLE = 0, stay in HELD indefinitely.
  - GAP, out = 1 for exactly one window:
    - Released → go to RELEASED.
    - Otherwise → go to REPEAT, out = 0, cnt = 0.
  - REPEAT, out = 0:
    - Released → go to RELEASED, out = 1.
    - Otherwise cnt++. On the (REPEAT_PERIOD_TICKS-1)-th tick in REPEAT → go to GAP, out = 1.
  - Result: falling edges of button_out occur every REPEAT_PERIOD_TICKS windows while the button is held.
- Channels are fully independent. Simultaneous presses are passed through unchanged; arbitration is the paddle stage's job.
- Counter widths are $clog2 of the respective maximum. Counters never overflow; they saturate at their terminal values.
- Reset mid-operation: outputs return to reset values immediately (asynchronously). The first tick after reset release follows the rule above.

Test Plan:
(All cases use DEBOUNCE_CYCLES=4, TICK_DIVIDER=10, REPEAT_DELAY_TICKS=3, REPEAT_PERIOD_TICKS=2.)
1. Reset, then idle with raw = 2'b11 → button_out = 2'b11, button_level = 2'b11; tick high in cycles 9, 19, 29… after release, one cycle wide.
2. raw[0] low pulses of 1, 2 and 3 cycles separated by highs → button_level[0] stays 1. Then raw[0] held low → button_level[0] = 0 exactly 6 cycles after the raw edge.
3. raw[0] held low → button_out[0] falls at the first tick after button_level falls. Pattern per window: 0,0,0,1,0,1,0,1… and button_out never changes except at tick edges.
4. Release during the REPEAT state → button_out[0] = 1 at the next tick edge. An immediate re-press restarts the full 3-window delay before the first repeat.
5. pause = 1 for 25 cycles while held → tick = 0, button_out frozen, tick counter holds. After pause drops, the next tick occurs after the remaining cycles of the interrupted count.
6. Both buttons pressed in the same cycle, then reset asserted mid-REPEAT → both channels toggle identically. Asserting reset forces button_out = 2'b11 and tick = 0 immediately, without waiting for a clock edge.
